// File: rtl/shift_add_multiplier_if.sv
// Operation bus for the shift-add multiplier: start + operands in, status + product out.
// Latency: none, this is wiring only.
// Backpressure: none; the requester watches busy/done before issuing start.
interface shift_add_multiplier_if;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  // Requester side: issues operations and reads results
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  // Multiplier side: accepts operations and returns results
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-add multiplier driving one 4-bit adder per iteration.
// Latency: start at edge k -> busy after k..k+3, product valid with one-cycle done after k+4.
// Backpressure: start is only accepted in IDLE or DONE; it is ignored while busy.

// Plain 4-bit ripple adder; the multiplier keeps its carry-out in the shift chain.
module FourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module shift_add_multiplier (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_multiplier_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_m;
  logic [3:0] r_a;
  logic [3:0] r_q;
  logic       r_c;
  logic [1:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_product;

  logic [3:0] w_sum;
  logic       w_cout;
  logic [4:0] w_acc;
  logic [3:0] w_a_shift;
  logic [3:0] w_q_shift;
  logic       w_load;

  // Partial-product add: A + M, carry-in unused
  FourBitAdder u_adder (
    .a    (r_a),
    .b    (r_m),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Conditional add on Q[0]; C is always cleared by the previous shift, so {C,A} is {0,A}
  assign w_acc     = r_q[0] ? {w_cout, w_sum} : {r_c, r_a};
  // Right shift of {C,A,Q}: zero enters C, carry drops into A[3], A[0] drops into Q[3]
  assign w_a_shift = w_acc[4:1];
  assign w_q_shift = {w_acc[0], r_q[3:1]};

  assign w_load = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Control FSM and datapath; all outputs come straight from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_m       <= 4'h0;
      r_a       <= 4'h0;
      r_q       <= 4'h0;
      r_c       <= 1'b0;
      r_cnt     <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_m     <= bus.multiplicand;
            r_q     <= bus.multiplier;
            r_a     <= 4'h0;
            r_c     <= 1'b0;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= w_a_shift;
          r_q   <= w_q_shift;
          r_c   <= 1'b0;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            // Fourth iteration: publish the post-shift {A,Q}
            r_product <= {w_a_shift, w_q_shift};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with hand-computed products.
// Latency: checks 4 busy cycles then a single done cycle per operation.
// Backpressure: exercises start ignored while busy and start held through DONE.
module tb_shift_add_multiplier;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  shift_add_multiplier_if bus ();

  shift_add_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count negedges with done low (bounded), checking busy/done never overlap
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy && bus.done) check("overlap", 1, 0);
      cyc++;
      @(negedge clk);
    end
    check("done_seen", 32'(bus.done), 1);
    check("overlap_done", 32'(bus.busy), 0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] m, input logic [3:0] q,
                        input logic [7:0] exp);
    int cyc;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 1);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 4);
    check({tag, "_prod"}, 32'(bus.product), 32'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.done), 0);
    check({tag, "_hold"}, 32'(bus.product), 32'(exp));
  endtask

  initial begin
    int cyc;
    int dones;
    n_cmp            = 0;
    n_err            = 0;
    rst_n            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = 4'h0;
    bus.multiplier   = 4'h0;

    // Asynchronous reset before the first clock edge
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_prod", 32'(bus.product), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and carry-path operations
    run_op("5x3", 4'd5, 4'd3, 8'h0F);
    run_op("15x15", 4'd15, 4'd15, 8'hE1);
    run_op("10x5", 4'd10, 4'd5, 8'h32);
    run_op("0x9", 4'd0, 4'd9, 8'h00);

    // start held during RUN with new operands must be ignored
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 4'd6;
    bus.multiplier   = 4'd7;
    @(negedge clk);
    bus.multiplicand = 4'd1;
    bus.multiplier   = 4'd1;
    wait_done(cyc);
    bus.start = 1'b0;
    check("ign_lat", cyc, 4);
    check("ign_prod", 32'(bus.product), 32'h2A);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("ign_extra_done", dones, 0);
    check("ign_idle_busy", 32'(bus.busy), 0);

    // Back-to-back: start held through DONE queues the next operation
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 4'd2;
    bus.multiplier   = 4'd2;
    @(negedge clk);
    bus.multiplicand = 4'd3;
    bus.multiplier   = 4'd4;
    wait_done(cyc);
    check("b2b_lat1", cyc, 4);
    check("b2b_prod1", 32'(bus.product), 32'h04);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy_rise", 32'(bus.busy), 1);
    check("b2b_done_fall", 32'(bus.done), 0);
    wait_done(cyc);
    check("b2b_spacing", cyc + 1, 5);
    check("b2b_prod2", 32'(bus.product), 32'h0C);
    @(negedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 4'd9;
    bus.multiplier   = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_prod", 32'(bus.product), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mid_no_done", dones, 0);
    check("mid_prod_zero", 32'(bus.product), 0);
    run_op("9x9", 4'd9, 4'd9, 8'h51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
